harris_response: RTL and testbench
==================================

# harris_response

Downstream of the 3x3 window generator in the Harris corner path. Consumes three time-aligned 3x3 windows of gradient products (Ixx, Iyy, Ixy), one window per cycle while the shared window valid is high. Fixed 5-stage pipeline with no backpressure that computes:

- the window sums A, C, B;
- the Harris response R = (A·C − B²) − (A+C)² >>> K_SHIFT.

It thresholds R and tags each result with its window column/row. It also counts corners per frame.

## Interface
Parameters:
- IMG_W, 512, pixels per line; window columns per row.
- WIN_ROWS, 510, window rows per frame (IMG_H − 2).
- K_SHIFT, 4, Harris k = 2^-K_SHIFT.

Ports:
- clk  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- win_xx  in  3x3 × 32  signed Ixx window, [row][col].
- win_yy  in  3x3 × 32  signed Iyy window.
- win_xy  in  3x3 × 32  signed Ixy window.
- win_valid  in  1  all three windows valid this cycle.
- threshold  in  32  signed corner threshold, sign-extended for compare; quasi-static.
- resp  out  76  signed Harris response.
- resp_valid  out  1  resp/corner/coords valid.
- corner  out  1  resp > threshold (strict); qualified by resp_valid.
- win_col  out  9  column index of the result window.
- win_row  out  9  row index of the result window.
- frame_done  out  1  one-cycle pulse with the last result of a frame.
- corner_count  out  32  corners in the current frame.

## Operation
- **Position counters.**
  - col/row advance on each accepted win_valid.
  - col wraps IMG_W−1→0 and increments row.
  - row wraps WIN_ROWS−1→0.
  - Captured values travel with the data through the pipeline.
- **Stage 1.** Per channel, three row sums, each 34-bit sign-extended.
- **Stage 2.** Window sums A (xx), C (yy), B (xy), each 36-bit signed.
- **Stage 3.** Registers AC = A·C and BB = B·B (72-bit), and T = A+C (37-bit).
- **Stage 4.**
  - det = AC − BB (73-bit).
  - KT = (T·T) >>> K_SHIFT: arithmetic, floor.
  - R = det − KT, computed sign-extended to 76 bits.
- **Stage 5.** Registers resp, corner = (R > sext(threshold)), win_col, win_row, and frame_done (last col and last row).
- **corner_count.**
  - Increments when resp_valid & corner.
  - Is cleared on the cycle after frame_done.
  - The pulse cycle itself still shows the final count, including a corner on that cycle.
  - Saturates at 2^32−1.
- **Bubbles.** win_valid low inserts a bubble. The valid bit propagates per stage, data registers may hold garbage, and the counters do not advance.
- **Overflow.** No overflow is possible at these widths; no saturation is needed in the datapath.

## Timing
- **Latency.** win_valid at cycle t gives resp_valid at t+5. Throughput is one window per cycle.
- **Reset values.** All outputs are 0: resp, resp_valid, corner, win_col, win_row, frame_done, corner_count. Internal valid pipe and col/row counters are also 0.
- **Reset mid-frame.** Everything in flight is discarded, with no output for the next 5 cycles unless new valid input arrives. Counters restart at (0,0).
- **win_valid in the reset cycle** is ignored.
- **threshold** is sampled at stage 5; a change mid-frame takes effect for results leaving stage 4 on that edge.
- **Simultaneous frame_done & corner:** that corner counts, then the counter clears next cycle.

## Structure
- **Package harris_pkg:**
  - width constants: PIX_W = 32, SUM_W = 36, PROD_W = 72, RESP_W = 76;
  - default IMG_W, WIN_ROWS, K_SHIFT;
  - the 3x3 window typedef shared with the window generator.
- **Sub-module window_sum3x3:** stages 1–2 with valid pass-through, instantiated three times.
- The top holds the position counters, stages 3–5 and the corner counter.

## Test plan
- **Zero windows,** threshold 0, one valid pulse → 5 cycles later resp_valid = 1, resp = 0, corner = 0, col = 0, row = 0.
- **Uniform windows** xx = 1, yy = 1, xy = 0, K_SHIFT = 4:
  - A = C = 9, det = 81, T² = 324 → KT = 20, R = 61.
  - threshold 60 → corner = 1.
  - threshold 61 → corner = 0.
- **Negative B:** xx = 1, yy = 1, xy = −1 → B = −9, det = 0, R = −20. With threshold −21 → corner = 1.
- **Streaming with random bubbles** (IMG_W = 8, WIN_ROWS = 3):
  - col sequence 0..7 wraps and row increments;
  - frame_done pulses exactly at (7,2);
  - results match a reference model in order;
  - no output appears for bubbles.
- **Corner counting:** every window above threshold in a 24-window frame → corner_count = 24 on the frame_done cycle, 0 the next cycle.
- **Reset asserted mid-frame** with 3 windows in flight → no resp_valid after reset. The next window reports col = 0, row = 0, and corner_count = 0.

Source files
------------

// File: rtl/harris_pkg.sv
// rtl/harris_pkg.sv - shared widths, defaults and window/position types for the Harris response path
package harris_pkg;

  localparam int PIX_W  = 32;
  localparam int ROW_W  = 34;
  localparam int SUM_W  = 36;
  localparam int T_W    = 37;
  localparam int PROD_W = 72;
  localparam int DET_W  = 73;
  localparam int TSQ_W  = 74;
  localparam int RESP_W = 76;
  localparam int POS_W  = 9;
  localparam int CNT_W  = 32;

  localparam int DEF_IMG_W    = 512;
  localparam int DEF_WIN_ROWS = 510;
  localparam int DEF_K_SHIFT  = 4;

  // 3x3 window, indexed [row][col], elements are signed two's complement.
  typedef logic [2:0][2:0][PIX_W-1:0] win3x3_t;

  typedef struct packed {
    logic [POS_W-1:0] col;
    logic [POS_W-1:0] row;
    logic             last;
  } pos_t;

endpackage

// File: rtl/window_sum3x3.sv
// rtl/window_sum3x3.sv - two-stage signed sum of a 3x3 window (row sums, then window sum)
module window_sum3x3
  import harris_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  win3x3_t                 win_i,
  input  logic                    valid_i,
  output logic signed [SUM_W-1:0] sum_o,
  output logic                    valid_o
);

  logic signed [ROW_W-1:0] row_sum_q [3];
  logic signed [SUM_W-1:0] sum_q;
  logic                    v1_q;
  logic                    v2_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= valid_i;
      v2_q <= v1_q;
    end
  end

  // Data stages run freely; only the valid bits qualify them.
  always_ff @(posedge clk_i) begin
    for (int r = 0; r < 3; r++) begin
      row_sum_q[r] <= ROW_W'($signed(win_i[r][0])) + ROW_W'($signed(win_i[r][1]))
                    + ROW_W'($signed(win_i[r][2]));
    end
    sum_q <= SUM_W'(row_sum_q[0]) + SUM_W'(row_sum_q[1]) + SUM_W'(row_sum_q[2]);
  end

  assign sum_o   = sum_q;
  assign valid_o = v2_q;

endmodule

// File: rtl/harris_response.sv
// rtl/harris_response.sv - 5-stage Harris response, threshold, window position tagging and per-frame corner count
module harris_response
  import harris_pkg::*;
#(
  parameter int IMG_W    = DEF_IMG_W,
  parameter int WIN_ROWS = DEF_WIN_ROWS,
  parameter int K_SHIFT  = DEF_K_SHIFT
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  win3x3_t                  win_xx_i,
  input  win3x3_t                  win_yy_i,
  input  win3x3_t                  win_xy_i,
  input  logic                     win_valid_i,
  input  logic signed [PIX_W-1:0]  threshold_i,
  output logic signed [RESP_W-1:0] resp_o,
  output logic                     resp_valid_o,
  output logic                     corner_o,
  output logic [POS_W-1:0]         win_col_o,
  output logic [POS_W-1:0]         win_row_o,
  output logic                     frame_done_o,
  output logic [CNT_W-1:0]         corner_count_o
);

  logic [POS_W-1:0] col_q, col_d;
  logic [POS_W-1:0] row_q, row_d;
  logic             last_w;
  pos_t             pos_q [4];

  logic signed [SUM_W-1:0] a_w, c_w, b_w;
  logic                    va_w, vc_w, vb_w;

  logic signed [PROD_W-1:0] ac_q, bb_q;
  logic signed [T_W-1:0]    t_q;
  logic                     v3_q;

  logic signed [DET_W-1:0]  det_w;
  logic signed [TSQ_W-1:0]  tsq_w, kt_w;
  logic signed [RESP_W-1:0] r_w;
  logic signed [RESP_W-1:0] r4_q;
  logic                     v4_q;

  logic signed [RESP_W-1:0] resp_q;
  logic                     corner_q, corner_d;
  logic                     resp_valid_q;
  logic [POS_W-1:0]         out_col_q, out_row_q;
  logic                     frame_done_q;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  assign last_w = (col_q == POS_W'(IMG_W - 1)) && (row_q == POS_W'(WIN_ROWS - 1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (win_valid_i) begin
      if (col_q == POS_W'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_q == POS_W'(WIN_ROWS - 1)) ? '0 : row_q + POS_W'(1);
      end else begin
        col_d = col_q + POS_W'(1);
      end
    end
  end

  window_sum3x3 u_sum_xx (.clk_i(clk_i), .reset_i(reset_i), .win_i(win_xx_i),
                          .valid_i(win_valid_i), .sum_o(a_w), .valid_o(va_w));
  window_sum3x3 u_sum_yy (.clk_i(clk_i), .reset_i(reset_i), .win_i(win_yy_i),
                          .valid_i(win_valid_i), .sum_o(c_w), .valid_o(vc_w));
  window_sum3x3 u_sum_xy (.clk_i(clk_i), .reset_i(reset_i), .win_i(win_xy_i),
                          .valid_i(win_valid_i), .sum_o(b_w), .valid_o(vb_w));

  always_comb begin
    det_w    = DET_W'(ac_q) - DET_W'(bb_q);
    tsq_w    = TSQ_W'(t_q) * TSQ_W'(t_q);
    kt_w     = tsq_w >>> K_SHIFT;
    r_w      = RESP_W'(det_w) - RESP_W'(kt_w);
    corner_d = r4_q > RESP_W'(threshold_i);
  end

  // Clear is applied first so a corner arriving right after the pulse opens the new frame's count.
  always_comb begin
    cnt_d = frame_done_q ? '0 : cnt_q;
    if (v4_q && corner_d && (cnt_d != '1)) begin
      cnt_d = cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    pos_q[0] <= {col_q, row_q, last_w};
    for (int i = 1; i < 4; i++) begin
      pos_q[i] <= pos_q[i-1];
    end
    ac_q <= PROD_W'(a_w) * PROD_W'(c_w);
    bb_q <= PROD_W'(b_w) * PROD_W'(b_w);
    t_q  <= T_W'(a_w) + T_W'(c_w);
    r4_q <= r_w;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      col_q        <= '0;
      row_q        <= '0;
      v3_q         <= 1'b0;
      v4_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
      corner_q     <= 1'b0;
      out_col_q    <= '0;
      out_row_q    <= '0;
      frame_done_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      v3_q         <= va_w & vc_w & vb_w;
      v4_q         <= v3_q;
      resp_valid_q <= v4_q;
      resp_q       <= r4_q;
      corner_q     <= corner_d;
      out_col_q    <= pos_q[3].col;
      out_row_q    <= pos_q[3].row;
      frame_done_q <= v4_q & pos_q[3].last;
      cnt_q        <= cnt_d;
    end
  end

  assign resp_o         = resp_q;
  assign resp_valid_o   = resp_valid_q;
  assign corner_o       = corner_q;
  assign win_col_o      = out_col_q;
  assign win_row_o      = out_row_q;
  assign frame_done_o   = frame_done_q;
  assign corner_count_o = cnt_q;

endmodule

// File: tb/tb_harris_response.sv
// tb/tb_harris_response.sv - directed bench for harris_response on an 8x3-window frame
module tb_harris_response;
  import harris_pkg::*;

  localparam int TB_IMG_W    = 8;
  localparam int TB_WIN_ROWS = 3;
  localparam int TB_K        = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  win3x3_t                  win_xx, win_yy, win_xy;
  logic                     win_valid;
  logic signed [PIX_W-1:0]  threshold;
  logic signed [RESP_W-1:0] resp;
  logic                     resp_valid, corner, frame_done;
  logic [POS_W-1:0]         win_col, win_row;
  logic [CNT_W-1:0]         corner_count;

  always #5 clk = ~clk;

  harris_response #(.IMG_W(TB_IMG_W), .WIN_ROWS(TB_WIN_ROWS), .K_SHIFT(TB_K)) dut (
    .clk_i(clk), .reset_i(reset),
    .win_xx_i(win_xx), .win_yy_i(win_yy), .win_xy_i(win_xy),
    .win_valid_i(win_valid), .threshold_i(threshold),
    .resp_o(resp), .resp_valid_o(resp_valid), .corner_o(corner),
    .win_col_o(win_col), .win_row_o(win_row),
    .frame_done_o(frame_done), .corner_count_o(corner_count)
  );

  typedef struct packed {
    logic signed [RESP_W-1:0] resp;
    logic                     corner;
    logic [POS_W-1:0]         col;
    logic [POS_W-1:0]         row;
    logic                     fd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_got    = 0;
  int   exp_cnt  = 0;
  bit   clear_pending = 1'b0;
  int   tb_col = 0;
  int   tb_row = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic win3x3_t mk_win(input logic signed [PIX_W-1:0] v);
    win3x3_t w;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++) w[r][k] = v;
    return w;
  endfunction

  function automatic win3x3_t rand_win();
    win3x3_t w;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++) w[r][k] = $urandom();
    return w;
  endfunction

  function automatic logic signed [RESP_W-1:0] ref_resp(input win3x3_t xx, input win3x3_t yy,
                                                       input win3x3_t xy);
    logic signed [127:0] a, c, b, t, det, kt;
    a = '0; c = '0; b = '0;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++) begin
        a += 128'($signed(xx[r][k]));
        c += 128'($signed(yy[r][k]));
        b += 128'($signed(xy[r][k]));
      end
    det = a * c - b * b;
    t   = a + c;
    kt  = (t * t) >>> TB_K;
    return RESP_W'(det - kt);
  endfunction

  task automatic send(input win3x3_t xx, input win3x3_t yy, input win3x3_t xy,
                      input logic signed [RESP_W-1:0] r, input logic c);
    exp_t e;
    e.resp   = r;
    e.corner = c;
    e.col    = POS_W'(tb_col);
    e.row    = POS_W'(tb_row);
    e.fd     = (tb_col == TB_IMG_W - 1) && (tb_row == TB_WIN_ROWS - 1);
    exp_q.push_back(e);
    win_xx = xx; win_yy = yy; win_xy = xy;
    win_valid = 1'b1;
    step();
    win_valid = 1'b0;
    if (tb_col == TB_IMG_W - 1) begin
      tb_col = 0;
      tb_row = (tb_row == TB_WIN_ROWS - 1) ? 0 : tb_row + 1;
    end else begin
      tb_col++;
    end
  endtask

  task automatic do_reset(input bit valid_during_reset);
    reset = 1'b1;
    win_xx = mk_win(1); win_yy = mk_win(1); win_xy = mk_win(0);
    win_valid = valid_during_reset;
    step();
    win_valid = 1'b0;
    step();
    reset = 1'b0;
    exp_q.delete();
    tb_col = 0; tb_row = 0;
    exp_cnt = 0; clear_pending = 1'b0;
  endtask

  task automatic drain();
    repeat (8) step();
    check_eq("drain_pending", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (clear_pending) begin
        exp_cnt = 0;
        clear_pending = 1'b0;
      end
      if (resp_valid) begin
        n_got++;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_resp", resp_valid, 0);
        end else begin
          e = exp_q.pop_front();
          if (e.corner) exp_cnt++;
          check_eq("resp", resp, e.resp);
          check_eq("corner", corner, e.corner);
          check_eq("win_col", win_col, e.col);
          check_eq("win_row", win_row, e.row);
          check_eq("frame_done", frame_done, e.fd);
          check_eq("corner_count", corner_count, exp_cnt);
          if (e.fd) clear_pending = 1'b1;
        end
      end else if (frame_done) begin
        check_eq("fd_idle", frame_done, 0);
      end
    end
  end

  initial begin
    win_valid = 1'b0;
    threshold = '0;
    do_reset(1'b0);

    check_eq("rst_resp", resp, 0);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_corner", corner, 0);
    check_eq("rst_col", win_col, 0);
    check_eq("rst_row", win_row, 0);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_count", corner_count, 0);

    threshold = 0;
    send(mk_win(0), mk_win(0), mk_win(0), 0, 1'b0);
    drain();
    threshold = 60;
    send(mk_win(1), mk_win(1), mk_win(0), 61, 1'b1);
    drain();
    threshold = 61;
    send(mk_win(1), mk_win(1), mk_win(0), 61, 1'b0);
    drain();
    threshold = -21;
    send(mk_win(1), mk_win(1), mk_win(-1), -20, 1'b1);
    drain();

    threshold = 0;
    for (int i = 0; i < 3; i++) send(mk_win(0), mk_win(0), mk_win(0), 0, 1'b0);
    do_reset(1'b1);
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("no_resp_after_reset", resp_valid, 0);
    end
    send(mk_win(0), mk_win(0), mk_win(0), 0, 1'b0);
    drain();

    do_reset(1'b0);
    n_got = 0;
    threshold = 0;
    for (int i = 0; i < TB_IMG_W * TB_WIN_ROWS; i++) begin
      win3x3_t xx, yy, xy;
      logic signed [RESP_W-1:0] r;
      repeat ($urandom_range(0, 2)) step();
      xx = rand_win(); yy = rand_win(); xy = rand_win();
      r = ref_resp(xx, yy, xy);
      send(xx, yy, xy, r, 128'(r) > 128'(threshold));
    end
    drain();
    check_eq("stream_count", n_got, TB_IMG_W * TB_WIN_ROWS);

    threshold = -100;
    for (int i = 0; i < TB_IMG_W * TB_WIN_ROWS; i++)
      send(mk_win(1), mk_win(1), mk_win(0), 61, 1'b1);
    for (int i = 0; i < 20 && !frame_done; i++) @(negedge clk);
    check_eq("fd_seen", frame_done, 1);
    check_eq("count_on_fd", corner_count, 24);
    @(negedge clk);
    check_eq("count_after_fd", corner_count, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
